// File: rtl/bft_stream_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module   : bft_stream_packetizer_if
// Purpose  : Bundles the user stream, the BFT packet buses and the credit
//            status of the stream packetizer into one interface.
// Ports    : master - driven by the host side (destination, user stream,
//                     returned packets, resend)
//            slave  - the packetizer (ack, outgoing packet, credit status)
// Revision : 1.0 - initial release
// ============================================================================
interface bft_stream_packetizer_if #(
    parameter int PACKET_BITS        = 49,
    parameter int PAYLOAD_BITS       = 32,
    parameter int NUM_LEAF_BITS      = 3,
    parameter int NUM_PORT_BITS      = 4,
    parameter int NUM_BRAM_ADDR_BITS = 7
) ();
    logic [NUM_LEAF_BITS-1:0]      dest_leaf;
    logic [NUM_PORT_BITS-1:0]      dest_port;
    logic [PAYLOAD_BITS-1:0]       din_user;
    logic                          vld_user;
    logic                          ack_user;
    logic [PACKET_BITS-1:0]        dout_pkt;
    logic [PACKET_BITS-1:0]        din_pkt;
    logic                          resend;
    logic [NUM_BRAM_ADDR_BITS:0]   credits;
    logic                          credit_err;

    modport master (
        output dest_leaf, dest_port, din_user, vld_user, din_pkt, resend,
        input  ack_user, dout_pkt, credits, credit_err
    );

    modport slave (
        input  dest_leaf, dest_port, din_user, vld_user, din_pkt, resend,
        output ack_user, dout_pkt, credits, credit_err
    );
endinterface
`default_nettype wire

// File: rtl/bft_stream_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : bft_stream_packetizer
// Purpose  : Transmit end of the leaf packet protocol. Wraps a 32-bit
//            vld/ack user stream into 49-bit BFT packets for one destination
//            leaf/port, and tracks receive-buffer credits returned by the
//            destination through freespace-update packets.
// Ports    : clk    - clock
//            reset  - asynchronous active-high reset
//            pkt_if - slave side of bft_stream_packetizer_if
//                     (dest_leaf/dest_port, din_user/vld_user/ack_user,
//                      dout_pkt, din_pkt, resend, credits, credit_err)
// Revision : 1.0 - initial release
// ============================================================================
module bft_stream_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 3,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    bft_stream_packetizer_if.slave     pkt_if
);
    localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
    // Headroom so credits + an 8-bit grant cannot wrap before the clamp test.
    localparam int SUM_BITS    = CREDIT_BITS + 2;
    localparam logic [CREDIT_BITS-1:0] MAX_CREDITS =
        {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};

    // Field boundaries inside a packet, MSB first.
    localparam int LEAF_LSB = PACKET_BITS - 1 - NUM_LEAF_BITS;
    localparam int PORT_LSB = LEAF_LSB - NUM_PORT_BITS;
    localparam int ADDR_LSB = PORT_LSB - NUM_ADDR_BITS;
    localparam int TYPE_LSB = PAYLOAD_BITS;

    localparam logic [1:0] TYPE_DATA  = 2'b00;
    localparam logic [1:0] TYPE_FREE  = 2'b01;
    localparam logic [1:0] TYPE_HELLO = 2'b10;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_HELLO = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                     state_q;
    logic [NUM_LEAF_BITS-1:0]   leaf_q;
    logic [NUM_PORT_BITS-1:0]   port_q;
    logic [NUM_ADDR_BITS-1:0]   addr_q;
    logic [CREDIT_BITS-1:0]     credits_q;
    logic [CREDIT_BITS-1:0]     credits_d;
    logic                       credit_err_q;
    logic [PACKET_BITS-1:0]     dout_q;

    logic                       ack;
    logic                       xfer;
    logic                       grant_hit;
    logic [7:0]                 grant;
    logic [SUM_BITS-1:0]        credit_sum;
    logic                       overflow;
    logic                       unused_pkt_bits;

    function automatic logic [PACKET_BITS-1:0] make_pkt(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port,
        input logic [NUM_ADDR_BITS-1:0] addr,
        input logic [1:0]               ptype,
        input logic [PAYLOAD_BITS-1:0]  payload
    );
        return {1'b1, leaf, port, addr, ptype, payload};
    endfunction

    // The hello payload advertises the full receive-buffer depth.
    function automatic logic [PACKET_BITS-1:0] hello_pkt(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port
    );
        return make_pkt(leaf, port, '0, TYPE_HELLO,
                        PAYLOAD_BITS'(MAX_CREDITS));
    endfunction

    always_comb begin
        // A resend cycle never accepts data, so the restart loses nothing.
        ack       = (state_q == S_RUN) && (credits_q != '0) && !pkt_if.resend;
        xfer      = ack && pkt_if.vld_user;
        // Destination is not latched until INIT completes, so no matching there.
        grant_hit = pkt_if.din_pkt[PACKET_BITS-1]
                 && (pkt_if.din_pkt[TYPE_LSB+1:TYPE_LSB] == TYPE_FREE)
                 && (pkt_if.din_pkt[PACKET_BITS-2:LEAF_LSB] == leaf_q)
                 && (pkt_if.din_pkt[LEAF_LSB-1:PORT_LSB] == port_q)
                 && (state_q != S_INIT);
        grant     = grant_hit ? pkt_if.din_pkt[7:0] : 8'd0;
        // xfer implies credits_q >= 1, so the subtraction cannot underflow.
        credit_sum = SUM_BITS'(credits_q) + SUM_BITS'(grant) - SUM_BITS'(xfer);
        overflow   = credit_sum > SUM_BITS'(MAX_CREDITS);
        credits_d  = overflow ? MAX_CREDITS : credit_sum[CREDIT_BITS-1:0];
    end

    assign unused_pkt_bits = ^{pkt_if.din_pkt[PORT_LSB-1:ADDR_LSB],
                               pkt_if.din_pkt[PAYLOAD_BITS-1:8]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            leaf_q       <= '0;
            port_q       <= '0;
            addr_q       <= '0;
            credits_q    <= MAX_CREDITS;
            credit_err_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    // Hello is registered here so it is on the bus while in HELLO.
                    leaf_q  <= pkt_if.dest_leaf;
                    port_q  <= pkt_if.dest_port;
                    dout_q  <= hello_pkt(pkt_if.dest_leaf, pkt_if.dest_port);
                    state_q <= S_HELLO;
                end
                S_HELLO: begin
                    dout_q       <= '0;
                    credits_q    <= credits_d;
                    credit_err_q <= credit_err_q | overflow;
                    state_q      <= S_RUN;
                end
                S_RUN: begin
                    if (pkt_if.resend) begin
                        // Restart: re-sample destination and re-announce.
                        leaf_q    <= pkt_if.dest_leaf;
                        port_q    <= pkt_if.dest_port;
                        dout_q    <= hello_pkt(pkt_if.dest_leaf, pkt_if.dest_port);
                        addr_q    <= '0;
                        credits_q <= MAX_CREDITS;
                        state_q   <= S_HELLO;
                    end else begin
                        if (xfer) begin
                            dout_q <= make_pkt(leaf_q, port_q, addr_q, TYPE_DATA,
                                               pkt_if.din_user);
                            addr_q <= addr_q + NUM_ADDR_BITS'(1);
                        end else begin
                            dout_q <= '0;
                        end
                        credits_q    <= credits_d;
                        credit_err_q <= credit_err_q | overflow;
                    end
                end
                default: begin
                    dout_q  <= '0;
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign pkt_if.ack_user   = ack;
    assign pkt_if.dout_pkt   = dout_q;
    assign pkt_if.credits    = credits_q;
    assign pkt_if.credit_err = credit_err_q;
endmodule
`default_nettype wire

// File: tb/tb_bft_stream_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bft_stream_packetizer
// Purpose  : Directed self-checking bench for bft_stream_packetizer: hello
//            after reset, data streaming, credit exhaustion and return,
//            same-cycle send/grant with clamping, address wrap, foreign
//            updates, resend restart and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bft_stream_packetizer;
    localparam int PACKET_BITS        = 49;
    localparam int PAYLOAD_BITS       = 32;
    localparam int NUM_LEAF_BITS      = 3;
    localparam int NUM_PORT_BITS      = 4;
    localparam int NUM_ADDR_BITS      = 7;
    localparam int NUM_BRAM_ADDR_BITS = 7;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bft_stream_packetizer_if #(
        .PACKET_BITS        (PACKET_BITS),
        .PAYLOAD_BITS       (PAYLOAD_BITS),
        .NUM_LEAF_BITS      (NUM_LEAF_BITS),
        .NUM_PORT_BITS      (NUM_PORT_BITS),
        .NUM_BRAM_ADDR_BITS (NUM_BRAM_ADDR_BITS)
    ) bus ();

    bft_stream_packetizer #(
        .PACKET_BITS        (PACKET_BITS),
        .PAYLOAD_BITS       (PAYLOAD_BITS),
        .NUM_LEAF_BITS      (NUM_LEAF_BITS),
        .NUM_PORT_BITS      (NUM_PORT_BITS),
        .NUM_ADDR_BITS      (NUM_ADDR_BITS),
        .NUM_BRAM_ADDR_BITS (NUM_BRAM_ADDR_BITS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pkt_if (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [6:0] m_addr;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic logic [48:0] pkt(input logic [2:0] l, input logic [3:0] p,
                                        input logic [6:0] a, input logic [1:0] t,
                                        input logic [31:0] d);
        return {1'b1, l, p, a, t, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted word: ack must be high before the edge, packet one cycle later.
    task automatic send(input logic [31:0] d, input string tag);
        bus.vld_user = 1'b1;
        bus.din_user = d;
        check({tag, "_ack"}, 64'(bus.ack_user), 64'd1);
        tick();
        check(tag, 64'(bus.dout_pkt), 64'(pkt(3'd4, 4'd1, m_addr, 2'b00, d)));
        m_addr++;
    endtask

    initial begin
        bus.dest_leaf = 3'd4;
        bus.dest_port = 4'd1;
        bus.din_user  = '0;
        bus.vld_user  = 1'b0;
        bus.din_pkt   = '0;
        bus.resend    = 1'b0;
        reset         = 1'b1;
        m_addr        = '0;
        repeat (2) tick();

        check("rst_dout",    64'(bus.dout_pkt),   64'd0);
        check("rst_ack",     64'(bus.ack_user),   64'd0);
        check("rst_credits", 64'(bus.credits),    64'd128);
        check("rst_err",     64'(bus.credit_err), 64'd0);

        @(negedge clk);
        reset = 1'b0;
        tick();                                  // INIT -> HELLO
        check("hello_pkt", 64'(bus.dout_pkt),
              64'(pkt(3'd4, 4'd1, 7'd0, 2'b10, 32'h80)));
        check("hello_ack", 64'(bus.ack_user), 64'd0);
        bus.dest_leaf = 3'd3;                    // must not affect packets
        tick();                                  // HELLO -> RUN
        check("run_ack",  64'(bus.ack_user), 64'd1);
        check("run_dout", 64'(bus.dout_pkt), 64'd0);

        for (int i = 0; i < 5; i++) send(32'hA0 + 32'(i), "stream");
        bus.vld_user = 1'b0;
        tick();
        check("idle_dout",   64'(bus.dout_pkt), 64'd0);
        check("credits_123", 64'(bus.credits),  64'd123);

        // Drain the remaining credits; addr walks 5..127.
        for (int i = 0; i < 123; i++) send(32'h1000 + 32'(i), "bulk");
        check("empty_credits", 64'(bus.credits),  64'd0);
        check("empty_ack",     64'(bus.ack_user), 64'd0);

        bus.din_pkt = pkt(3'd4, 4'd1, 7'd0, 2'b01, 32'd64);
        tick();
        bus.din_pkt = '0;
        check("empty_nopkt",  64'(bus.dout_pkt), 64'd0);
        check("grant_64",     64'(bus.credits),  64'd64);
        check("grant_ack",    64'(bus.ack_user), 64'd1);

        send(32'hB0, "wrap_addr0");              // addr 0 after 127
        send(32'hB1, "wrap_addr1");
        bus.vld_user = 1'b0;

        bus.din_pkt = pkt(3'd3, 4'd1, 7'd0, 2'b01, 32'd5);
        tick();
        check("foreign_leaf", 64'(bus.credits), 64'd62);
        bus.din_pkt = pkt(3'd4, 4'd1, 7'd0, 2'b00, 32'd5);
        tick();
        check("data_type_ignored", 64'(bus.credits), 64'd62);
        bus.din_pkt = pkt(3'd4, 4'd2, 7'd0, 2'b01, 32'd5);
        tick();
        check("foreign_port", 64'(bus.credits), 64'd62);
        bus.din_pkt = pkt(3'd4, 4'd1, 7'd0, 2'b01, 32'd3);
        tick();
        bus.din_pkt = '0;
        check("grant_3", 64'(bus.credits), 64'd65);

        // 65 + 64 - 1 = 128 lands exactly on the limit: no error.
        bus.din_pkt = pkt(3'd4, 4'd1, 7'd0, 2'b01, 32'd64);
        send(32'hC0, "same_cycle_65");
        bus.din_pkt = '0;
        check("sc65_credits", 64'(bus.credits),    64'd128);
        check("sc65_err",     64'(bus.credit_err), 64'd0);

        for (int i = 0; i < 8; i++) send(32'hC8 + 32'(i), "to120");
        check("credits_120", 64'(bus.credits), 64'd120);
        // 120 + 64 - 1 = 183 clamps and flags the error.
        bus.din_pkt = pkt(3'd4, 4'd1, 7'd0, 2'b01, 32'd64);
        send(32'hD0, "same_cycle_120");
        bus.din_pkt = '0;
        check("sc120_credits", 64'(bus.credits),    64'd128);
        check("sc120_err",     64'(bus.credit_err), 64'd1);

        bus.dest_leaf = 3'd4;
        send(32'hE0, "pre_resend");
        bus.resend = 1'b1;
        #1;
        check("resend_ack", 64'(bus.ack_user), 64'd0);
        tick();
        bus.resend = 1'b0;
        check("resend_hello", 64'(bus.dout_pkt),
              64'(pkt(3'd4, 4'd1, 7'd0, 2'b10, 32'h80)));
        check("resend_credits", 64'(bus.credits),    64'd128);
        check("resend_err",     64'(bus.credit_err), 64'd1);
        check("resend_hello_ack", 64'(bus.ack_user), 64'd0);
        tick();
        check("resend_run_dout", 64'(bus.dout_pkt), 64'd0);
        m_addr = '0;
        send(32'hF0, "resend_addr0");
        send(32'hF1, "resend_addr1");
        check("resend_credits_126", 64'(bus.credits), 64'd126);

        reset = 1'b1;
        #1;
        check("async_dout",    64'(bus.dout_pkt),   64'd0);
        check("async_ack",     64'(bus.ack_user),   64'd0);
        check("async_credits", 64'(bus.credits),    64'd128);
        check("async_err",     64'(bus.credit_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
